// File: rtl/sequence_gen_pkg.sv
// sequence_gen_pkg: FSM encoding and default pattern shared by the sequence generator and detector
package sequence_gen_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    localparam logic [7:0] DEFAULT_PATTERN = 8'b0111_0001;

endpackage

// File: rtl/sequence_gen.sv
// sequence_gen: emits bursts of 8-bit frames MSB first with optional idle gaps between frames
module sequence_gen
    import sequence_gen_pkg::*;
#(
    parameter logic [7:0] PATTERN = DEFAULT_PATTERN,
    parameter int         CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pat_sel,
    input  logic [7:0]       pat_in,
    input  logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] gap,
    output logic             dout,
    output logic             dout_vld,
    output logic             frame_last,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [7:0]       pat;
    logic [CNT_W-1:0] frames;
    logic [CNT_W-1:0] gap_len;
    logic [CNT_W-1:0] gap_cnt;
    logic [2:0]       bit_cnt;
    logic [2:0]       nxt;
    logic [7:0]       sel_pat;

    assign sel_pat = pat_sel ? pat_in : PATTERN;
    assign nxt     = bit_cnt - 3'd1;

    // bit_cnt indexes the bit currently on dout; its wrap from 0 to 7 lines up the next frame's MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pat        <= '0;
            frames     <= '0;
            gap_len    <= '0;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            dout       <= 1'b0;
            dout_vld   <= 1'b0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    pat     <= sel_pat;
                    frames  <= count;
                    gap_len <= gap;
                    bit_cnt <= 3'd7;
                    if (count != '0) begin
                        state    <= SEND;
                        dout     <= sel_pat[7];
                        dout_vld <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                SEND: begin
                    bit_cnt <= nxt;
                    if (bit_cnt != 3'd0) begin
                        dout       <= pat[nxt];
                        frame_last <= (nxt == 3'd0);
                    end else begin
                        frames     <= frames - CNT_W'(1);
                        frame_last <= 1'b0;
                        if (frames == CNT_W'(1)) begin
                            state    <= FIN;
                            dout     <= 1'b0;
                            dout_vld <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else if (gap_len != '0) begin
                            state    <= GAP;
                            gap_cnt  <= gap_len;
                            dout     <= 1'b0;
                            dout_vld <= 1'b0;
                        end else begin
                            dout <= pat[7];
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == CNT_W'(1)) begin
                        state    <= SEND;
                        dout     <= pat[7];
                        dout_vld <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - CNT_W'(1);
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
